// File: rtl/branch_unit_pkg.sv
// branch_unit_pkg: shared definitions for the branch unit.
//   op_e        - decoder operation encodings (SEQ/JMP/CALL/RET)
//   COND_ALWAYS - condition selector value meaning "unconditional"
//   cond_eval   - resolves a condition selector against a flag vector
package branch_unit_pkg;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'b00,
        OP_JMP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    localparam int unsigned COND_ALWAYS = 0;

    // Widest flag vector cond_eval accepts; callers zero-extend into it.
    localparam int unsigned MAX_FLAGS = 32;

    // Selector 0 is always true, k in 1..n_flags picks flag k-1, anything
    // above n_flags is never true. neg inverts the result in every case.
    function automatic logic cond_eval(
        input int unsigned            cond,
        input logic                   neg,
        input logic [MAX_FLAGS-1:0]   flags,
        input int unsigned            n_flags
    );
        logic c;
        if (cond == COND_ALWAYS) begin
            c = 1'b1;
        end else if (cond <= n_flags) begin
            c = flags[5'(cond - 1)];
        end else begin
            c = 1'b0;
        end
        return c ^ neg;
    endfunction

endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: decoder/fetch-side bundle of the branch unit.
//   master - decoder side: drives i_* (enable, op, condition, target,
//            flag load, error clear), observes o_* (pc, flags, taken,
//            stack occupancy, sticky errors)
//   slave  - branch unit side
interface branch_unit_if #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned N_FLAGS     = 3,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned COND_W = $clog2(N_FLAGS + 1);
    localparam int unsigned SP_W   = $clog2(STACK_DEPTH) + 1;

    logic                i_en;
    logic [1:0]          i_op;
    logic [COND_W-1:0]   i_cond;
    logic                i_neg;
    logic [ADDR_W-1:0]   i_target;
    logic                i_flag_we;
    logic [N_FLAGS-1:0]  i_flags;
    logic                i_clr_err;

    logic [ADDR_W-1:0]   o_pc;
    logic [N_FLAGS-1:0]  o_flags;
    logic                o_taken;
    logic [SP_W-1:0]     o_sp;
    logic                o_ovf;
    logic                o_unf;

    modport master (
        output i_en, i_op, i_cond, i_neg, i_target, i_flag_we, i_flags, i_clr_err,
        input  o_pc, o_flags, o_taken, o_sp, o_ovf, o_unf
    );

    modport slave (
        input  i_en, i_op, i_cond, i_neg, i_target, i_flag_we, i_flags, i_clr_err,
        output o_pc, o_flags, o_taken, o_sp, o_ovf, o_unf
    );
endinterface

// File: rtl/branch_ret_stack.sv
// branch_ret_stack: hardware return-address LIFO.
//   i_clk, i_rst_n - clock, async active-low reset (clears occupancy only)
//   i_push, i_data - push i_data (caller never pushes when full)
//   i_pop          - discard top entry (caller never pops when empty)
//   o_top          - current top entry (undefined when empty)
//   o_sp           - occupancy 0..STACK_DEPTH
//   o_full/o_empty - occupancy flags
module branch_ret_stack #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_push,
    input  logic                                i_pop,
    input  logic [ADDR_W-1:0]                   i_data,
    output logic [ADDR_W-1:0]                   o_top,
    output logic [$clog2(STACK_DEPTH):0]        o_sp,
    output logic                                o_full,
    output logic                                o_empty
);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    // Depth is a power of two, so the low bits of sp address the next free
    // slot and the low bits of sp-1 address the top.
    assign wr_idx = sp_q[IDX_W-1:0];
    assign rd_idx = IDX_W'(sp_q - 1'b1);

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_idx] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sp_q <= '0;
        end else if (i_push) begin
            sp_q <= sp_q + 1'b1;
        end else if (i_pop) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    assign o_top   = mem[rd_idx];
    assign o_sp    = sp_q;
    assign o_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign o_empty = (sp_q == '0);
endmodule

// File: rtl/branch_unit.sv
// branch_unit: per-cycle sequential/jump/call/return decision and PC state.
//   i_clk, i_rst_n - clock, async active-low reset
//   bus (slave)    - decoder inputs (op, condition, target, flag load,
//                    error clear) and registered outputs (pc, flags,
//                    taken pulse, stack occupancy, sticky ovf/unf)
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       N_FLAGS     = 3,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    branch_unit_if.slave bus
);
    localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0]    pc_q;
    logic [N_FLAGS-1:0]   flags_q;
    logic                 taken_q;
    logic                 ovf_q;
    logic                 unf_q;

    logic [N_FLAGS-1:0]   eff_flags;
    logic [MAX_FLAGS-1:0] flags_ext;
    logic                 cond;
    logic [ADDR_W-1:0]    pc_inc;
    logic [ADDR_W-1:0]    pc_nxt;
    logic                 push;
    logic                 pop;
    logic                 take;
    logic                 set_ovf;
    logic                 set_unf;

    logic [ADDR_W-1:0]    stk_top;
    logic [SP_W-1:0]      stk_sp;
    logic                 stk_full;
    logic                 stk_empty;

    // A flag load in the same cycle is visible to this cycle's condition.
    assign eff_flags = bus.i_flag_we ? bus.i_flags : flags_q;
    assign pc_inc    = pc_q + 1'b1;

    always_comb begin
        flags_ext = '0;
        flags_ext[N_FLAGS-1:0] = eff_flags;
        cond = cond_eval(32'(bus.i_cond), bus.i_neg, flags_ext, N_FLAGS);
    end

    // Every action is gated by i_en here, so the stack and the taken pulse
    // need no further qualification downstream.
    always_comb begin
        pc_nxt  = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        take    = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (bus.i_en && cond) begin
            case (op_e'(bus.i_op))
                OP_JMP: begin
                    pc_nxt = bus.i_target;
                    take   = 1'b1;
                end
                OP_CALL: begin
                    if (!stk_full) begin
                        push   = 1'b1;
                        pc_nxt = bus.i_target;
                        take   = 1'b1;
                    end else begin
                        set_ovf = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!stk_empty) begin
                        pop    = 1'b1;
                        pc_nxt = stk_top;
                        take   = 1'b1;
                    end else begin
                        set_unf = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q    <= RESET_PC;
            flags_q <= '0;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.i_en) begin
                pc_q <= pc_nxt;
            end
            flags_q <= eff_flags;
            taken_q <= take;
            // A new error on the clearing edge still sets the bit.
            ovf_q   <= set_ovf | (ovf_q & ~bus.i_clr_err);
            unf_q   <= set_unf | (unf_q & ~bus.i_clr_err);
        end
    end

    branch_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (pc_inc),
        .o_top   (stk_top),
        .o_sp    (stk_sp),
        .o_full  (stk_full),
        .o_empty (stk_empty)
    );

    assign bus.o_pc    = pc_q;
    assign bus.o_flags = flags_q;
    assign bus.o_taken = taken_q;
    assign bus.o_sp    = stk_sp;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_unf   = unf_q;
endmodule
